// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: S-box, round constants, GF(2^8) xtime
// and the byte/word/state types used by the round datapath.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [7:0]       byte_t;
    typedef logic [0:3][7:0]  word_t;
    typedef logic [0:15][7:0] state_t;

    typedef enum logic {
        IDLE,
        ROUND
    } fsm_t;

    // Entry 0 sits in the leftmost (most significant) position of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: the fixed matrix {02 03 01 01} rotated per row.
    function automatic word_t mix_column(input word_t a);
        word_t m;
        m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
        return m;
    endfunction

endpackage

// File: rtl/aes128_encryption_if.sv
// Request/result bundle between the block controller (master) and the AES core (slave).
// All 128-bit fields use FIPS byte order: bit 0 is the MSB of byte 0.
interface aes128_encryption_if;

    logic         start;
    logic [0:127] key;
    logic [0:127] plain_text;
    logic [0:127] enc_data;
    logic         valid_flag;

    modport master (
        output start,
        output key,
        output plain_text,
        input  enc_data,
        input  valid_flag
    );

    modport slave (
        input  start,
        input  key,
        input  plain_text,
        output enc_data,
        output valid_flag
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: one byte in, its SubBytes substitution out.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t value,
    output byte_t substituted
);

    assign substituted = SBOX[value];

endmodule

// File: rtl/aes128_encryption.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly
// alongside the state so no key schedule storage is needed.
module aes128_encryption
    import aes_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    aes128_encryption_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    fsm_t       fsm;
    logic [3:0] round;
    state_t     state;
    state_t     rkey;

    state_t     sub_state;
    state_t     shifted;
    state_t     mixed;
    state_t     next_state;
    state_t     next_rkey;
    word_t      rot_word;
    word_t      sub_word;
    word_t      key_temp;
    word_t      nk0, nk1, nk2, nk3;
    byte_t      rcon;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .value       (state[i]),
            .substituted (sub_state[i])
        );
    end

    // Byte r + 4c is row r, column c; row r rotates left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
        for (genvar c = 0; c < 4; c++) begin : g_shift_col
            assign shifted[r + 4*c] = sub_state[r + 4*((c + r) % 4)];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[4*c +: 4] = mix_column(shifted[4*c +: 4]);
    end

    assign rot_word = {rkey[13], rkey[14], rkey[15], rkey[12]};

    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_word_sbox (
            .value       (rot_word[i]),
            .substituted (sub_word[i])
        );
    end

    always_comb begin
        rcon = 8'h00;
        if (round >= 4'd1 && round <= LAST_ROUND) begin
            rcon = RCON[round];
        end
    end

    assign key_temp   = {sub_word[0] ^ rcon, sub_word[1], sub_word[2], sub_word[3]};
    assign nk0        = rkey[0:3]   ^ key_temp;
    assign nk1        = rkey[4:7]   ^ nk0;
    assign nk2        = rkey[8:11]  ^ nk1;
    assign nk3        = rkey[12:15] ^ nk2;
    assign next_rkey  = {nk0, nk1, nk2, nk3};

    assign next_state = ((round == LAST_ROUND) ? shifted : mixed) ^ next_rkey;

    // Operands are captured on the edge that leaves IDLE, which also performs
    // the initial AddRoundKey, so ten ROUND edges follow for 11 in total.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm            <= IDLE;
            round          <= 4'd0;
            state          <= '0;
            rkey           <= '0;
            bus.enc_data   <= '0;
            bus.valid_flag <= 1'b0;
        end else begin
            bus.valid_flag <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        state <= bus.plain_text ^ bus.key;
                        rkey  <= bus.key;
                        round <= 4'd1;
                        fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    state <= next_state;
                    rkey  <= next_rkey;
                    if (round == LAST_ROUND) begin
                        bus.enc_data   <= next_state;
                        bus.valid_flag <= 1'b1;
                        round          <= 4'd0;
                        fsm            <= IDLE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    round <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encryption.sv
// Directed self-checking bench for aes128_encryption using FIPS-197 and hand-checked vectors.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes128_encryption;

    logic clock;
    logic reset;
    int   assertCount;
    int   failCount;

    localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] E1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K2 = 128'h00000000000000000000000000000000;
    localparam logic [0:127] P2 = 128'h00000101030307070f0f1f1f3f3f7f7f;
    localparam logic [0:127] E2 = 128'hc7d12419489e3b6233a2c5a7f4563172;
    localparam logic [0:127] K3 = 128'h4500600000ffab00cb00bddd00566644;
    localparam logic [0:127] P3 = 128'h1234abcd5678efef910a1fe2893f7abb;
    localparam logic [0:127] E3 = 128'h98e8f827e5544bdf58d4221147dc2b28;

    aes128_encryption_if bus ();

    aes128_encryption dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [0:127] k, input logic [0:127] p, input logic s);
        bus.key        = k;
        bus.plain_text = p;
        bus.start      = s;
    endtask

    task automatic waitEdges(input int n, output int valid_count);
        valid_count = 0;
        repeat (n) begin
            @(negedge clock);
            if (bus.valid_flag === 1'b1) valid_count++;
        end
    endtask

    // Single encryption: start for one cycle, result exactly 11 edges later.
    task automatic runBlock(input logic [0:127] k, input logic [0:127] p, input logic [0:127] e, input string tag);
        int vc;
        applyStimulus(k, p, 1'b1);
        @(negedge clock);
        applyStimulus(k, p, 1'b0);
        waitEdges(9, vc);
        checkOutput({tag, "_early_valid"}, 128'(vc), 128'd0);
        @(negedge clock);
        checkOutput({tag, "_valid"}, 128'(bus.valid_flag), 128'd1);
        checkOutput({tag, "_data"}, bus.enc_data, e);
        @(negedge clock);
        checkOutput({tag, "_pulse_end"}, 128'(bus.valid_flag), 128'd0);
        checkOutput({tag, "_data_hold"}, bus.enc_data, e);
    endtask

    initial begin
        int vc;
        int changed;
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b0;
        applyStimulus(K1, P1, 1'b0);

        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("reset_data", bus.enc_data, 128'd0);
        checkOutput("reset_valid", 128'(bus.valid_flag), 128'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] FIPS-197 C.1 and zero-key vectors");
        runBlock(K1, P1, E1, "c1");
        runBlock(K2, P2, E2, "zero_key");

        $display("[TB] back-to-back with start held high");
        applyStimulus(K1, P1, 1'b1);
        @(negedge clock);
        waitEdges(9, vc);
        checkOutput("b2b_first_early_valid", 128'(vc), 128'd0);
        @(negedge clock);
        checkOutput("b2b_first_valid", 128'(bus.valid_flag), 128'd1);
        checkOutput("b2b_first_data", bus.enc_data, E1);
        applyStimulus(K3, P3, 1'b1);
        @(negedge clock);
        applyStimulus(K3, P3, 1'b0);
        checkOutput("b2b_gap_valid", 128'(bus.valid_flag), 128'd0);
        changed = 0;
        vc      = 0;
        repeat (9) begin
            @(negedge clock);
            if (bus.enc_data !== E1) changed++;
            if (bus.valid_flag === 1'b1) vc++;
        end
        checkOutput("b2b_first_holds", 128'(changed), 128'd0);
        checkOutput("b2b_second_early_valid", 128'(vc), 128'd0);
        @(negedge clock);
        checkOutput("b2b_second_valid", 128'(bus.valid_flag), 128'd1);
        checkOutput("b2b_second_data", bus.enc_data, E3);
        @(negedge clock);

        $display("[TB] operand changes and start pulse while busy");
        applyStimulus(K1, P1, 1'b1);
        @(negedge clock);
        applyStimulus(K1, P1, 1'b0);
        vc = 0;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clock);
            if (bus.valid_flag === 1'b1) vc++;
            if (i >= 3 && i <= 7) begin
                applyStimulus({$urandom, $urandom, $urandom, $urandom},
                              {$urandom, $urandom, $urandom, $urandom}, (i == 4));
            end else begin
                applyStimulus(K2, P2, 1'b0);
            end
        end
        checkOutput("busy_early_valid", 128'(vc), 128'd0);
        @(negedge clock);
        checkOutput("busy_valid", 128'(bus.valid_flag), 128'd1);
        checkOutput("busy_data", bus.enc_data, E1);
        waitEdges(15, vc);
        checkOutput("busy_no_extra_op", 128'(vc), 128'd0);
        checkOutput("busy_data_hold", bus.enc_data, E1);

        $display("[TB] reset during round 5");
        applyStimulus(K2, P2, 1'b1);
        @(negedge clock);
        applyStimulus(K2, P2, 1'b0);
        waitEdges(4, vc);
        reset = 1'b1;
        #1;
        checkOutput("abort_data", bus.enc_data, 128'd0);
        checkOutput("abort_valid", 128'(bus.valid_flag), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        waitEdges(12, vc);
        checkOutput("abort_no_valid", 128'(vc), 128'd0);
        checkOutput("abort_data_zero", bus.enc_data, 128'd0);
        runBlock(K3, P3, E3, "after_reset");

        $display("[TB] long idle");
        waitEdges(30, vc);
        checkOutput("idle_no_valid", 128'(vc), 128'd0);
        checkOutput("idle_data_hold", bus.enc_data, E3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
